// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between client sequencers and the shared run-counter scheduler.
// Clients drive req/len; the scheduler drives grant, completion and counter status.
interface counter_scheduler_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 6
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] len;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              aborted;
   logic              busy;
   logic [IW-1:0]     owner;
   logic [W-1:0]      count;

   modport master (
      output req,
      output len,
      input  gnt,
      input  done,
      input  aborted,
      input  busy,
      input  owner,
      input  count
   );

   modport slave (
      input  req,
      input  len,
      output gnt,
      output done,
      output aborted,
      output busy,
      output owner,
      output count
   );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin scheduler lending one W-bit run counter to NREQ requesters, one run at a
// time, ending each run with a one-cycle done pulse (flagged aborted if req dropped).
module counter_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   counter_scheduler_if.slave  bus
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            r_state;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_done;
   logic              r_aborted;
   logic              r_busy;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_ptr;
   logic [W-1:0]      r_count;
   logic [W-1:0]      r_len;

   logic              w_sel_vld;
   logic [IW-1:0]     w_sel_idx;
   int                w_cand;
   logic [W-1:0]      w_sel_len;
   logic [IW-1:0]     w_ptr_next;
   logic              w_last;
   logic              w_drop;
   logic [NREQ-1:0]   w_one;

   assign w_one = {{(NREQ-1){1'b0}}, 1'b1};

   // Scan from the highest offset down so the lowest offset from r_ptr wins.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      w_cand    = 0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         w_cand = (int'(r_ptr) + k) % int'(NREQ);
         if (bus.req[w_cand]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = IW'(w_cand);
         end
      end
   end

   assign w_sel_len  = bus.len[int'(w_sel_idx)*int'(W) +: W];
   // len_q of zero wraps to all-ones here, giving a full 2^W-cycle run.
   assign w_last     = (r_count == (r_len - W'(1)));
   assign w_drop     = ~bus.req[r_owner];
   assign w_ptr_next = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_gnt     <= '0;
         r_done    <= '0;
         r_aborted <= 1'b0;
         r_busy    <= 1'b0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_count   <= '0;
         r_len     <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_sel_vld) begin
                  r_state <= StRun;
                  r_owner <= w_sel_idx;
                  r_gnt   <= w_one << w_sel_idx;
                  r_count <= '0;
                  r_len   <= w_sel_len;
                  r_busy  <= 1'b1;
               end
            end
            StRun: begin
               if (w_drop || w_last) begin
                  r_state   <= StDone;
                  r_gnt     <= '0;
                  r_done    <= w_one << r_owner;
                  r_aborted <= w_drop;
               end else begin
                  r_count <= r_count + W'(1);
               end
            end
            StDone: begin
               r_state   <= StIdle;
               r_done    <= '0;
               r_aborted <= 1'b0;
               r_busy    <= 1'b0;
               r_ptr     <= w_ptr_next;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.done    = r_done;
   assign bus.aborted = r_aborted;
   assign bus.busy    = r_busy;
   assign bus.owner   = r_owner;
   assign bus.count   = r_count;
endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: a run-length model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_counter_scheduler;
   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   counter_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

   counter_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: a run is "L cycles of grant left", then one done cycle, then arbitration.
   int m_ptr    = 0;
   int m_owner  = 0;
   int m_count  = 0;
   int m_left   = 0;
   bit m_dpulse = 1'b0;
   bit m_ab     = 1'b0;

   function automatic int pick(logic [NREQ-1:0] rq, int ptr);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (rq[(ptr + i) % int'(NREQ)]) return (ptr + i) % int'(NREQ);
      end
      return -1;
   endfunction

   function automatic int run_len(logic [NREQ*W-1:0] lv, int idx);
      int l;
      l = int'(lv[idx*int'(W) +: W]);
      return (l == 0) ? (1 << W) : l;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr    <= 0;
         m_owner  <= 0;
         m_count  <= 0;
         m_left   <= 0;
         m_dpulse <= 1'b0;
         m_ab     <= 1'b0;
      end else if (m_dpulse) begin
         m_dpulse <= 1'b0;
         m_ab     <= 1'b0;
         m_ptr    <= (m_owner + 1) % int'(NREQ);
      end else if (m_left > 0) begin
         if (!bus.req[m_owner]) begin
            m_left   <= 0;
            m_dpulse <= 1'b1;
            m_ab     <= 1'b1;
         end else if (m_left == 1) begin
            m_left   <= 0;
            m_dpulse <= 1'b1;
         end else begin
            m_left  <= m_left - 1;
            m_count <= m_count + 1;
         end
      end else if (pick(bus.req, m_ptr) >= 0) begin
         m_owner <= pick(bus.req, m_ptr);
         m_count <= 0;
         m_left  <= run_len(bus.len, pick(bus.req, m_ptr));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_gnt", 32'(bus.gnt), (m_left > 0) ? (32'd1 << m_owner) : 32'd0);
         chk("m_done", 32'(bus.done), m_dpulse ? (32'd1 << m_owner) : 32'd0);
         chk("m_aborted", 32'(bus.aborted), 32'(m_ab));
         chk("m_busy", 32'(bus.busy), 32'((m_left > 0) || m_dpulse));
         chk("m_owner", 32'(bus.owner), 32'(m_owner));
         chk("m_count", 32'(bus.count), 32'(m_count));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] d,
                      input logic [31:0] ab, input logic [31:0] bz, input logic [31:0] ow,
                      input logic [31:0] ct);
      chk({nm, "_gnt"}, 32'(bus.gnt), g);
      chk({nm, "_done"}, 32'(bus.done), d);
      chk({nm, "_aborted"}, 32'(bus.aborted), ab);
      chk({nm, "_busy"}, 32'(bus.busy), bz);
      chk({nm, "_owner"}, 32'(bus.owner), ow);
      chk({nm, "_count"}, 32'(bus.count), ct);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      bus.req = 4'($urandom);
      bus.len = 24'($urandom);
      step(1);
      chk_en = 1'b1;
      lit("t1_reset", 0, 0, 0, 0, 0, 0);
      step(1);
      lit("t1_reset_hold", 0, 0, 0, 0, 0, 0);
      bus.req = '0;
      rst_n   = 1'b1;
      step(1);

      // Single run of length 3 for requester 0.
      bus.req = 4'b0001;
      bus.len = {6'd0, 6'd0, 6'd0, 6'd3};
      step(1); lit("t2_c0", 1, 0, 0, 1, 0, 0);
      step(1); lit("t2_c1", 1, 0, 0, 1, 0, 1);
      step(1); lit("t2_c2", 1, 0, 0, 1, 0, 2);
      step(1); lit("t2_done", 0, 1, 0, 1, 0, 2);
      bus.req = '0;
      step(1); lit("t2_idle", 0, 0, 0, 0, 0, 2);

      // Two held requesters rotate 0, 2, 0 with one idle cycle between runs.
      pulse_reset();
      bus.req = 4'b0101;
      bus.len = {4{6'd2}};
      step(1); lit("t3_g0", 4'b0001, 0, 0, 1, 0, 0);
      step(1); lit("t3_g0c1", 4'b0001, 0, 0, 1, 0, 1);
      step(1); lit("t3_d0", 0, 4'b0001, 0, 1, 0, 1);
      step(1); lit("t3_idle1", 0, 0, 0, 0, 0, 1);
      step(1); lit("t3_g2", 4'b0100, 0, 0, 1, 2, 0);
      step(2); lit("t3_d2", 0, 4'b0100, 0, 1, 2, 1);
      step(1); lit("t3_idle2", 0, 0, 0, 0, 2, 1);
      step(1); lit("t3_g0b", 4'b0001, 0, 0, 1, 0, 0);
      step(2); lit("t3_d0b", 0, 4'b0001, 0, 1, 0, 1);
      bus.req = '0;
      step(1);

      // len of zero is a full 64-cycle run.
      bus.req = 4'b0010;
      bus.len = '0;
      step(1);  lit("t4_g", 4'b0010, 0, 0, 1, 1, 0);
      step(63); lit("t4_c63", 4'b0010, 0, 0, 1, 1, 63);
      step(1);  lit("t4_done", 0, 4'b0010, 0, 1, 1, 63);
      bus.req = '0;
      step(1);

      // Owner drops req mid-run: abort with count frozen.
      bus.req = 4'b1000;
      bus.len = {6'd10, 18'd0};
      step(1); lit("t5_g", 4'b1000, 0, 0, 1, 3, 0);
      step(4); lit("t5_c4", 4'b1000, 0, 0, 1, 3, 4);
      bus.req = '0;
      step(1); lit("t5_abort", 0, 4'b1000, 1, 1, 3, 4);
      step(1); lit("t5_idle", 0, 0, 0, 0, 3, 4);

      // Async reset mid-run clears the rr pointer.
      bus.req = 4'b0100;
      bus.len = {6'd0, 6'd5, 12'd0};
      step(3); lit("t6_run", 4'b0100, 0, 0, 1, 2, 2);
      rst_n = 1'b0;
      #1;      lit("t6_async", 0, 0, 0, 0, 0, 0);
      bus.req = 4'b1010;
      bus.len = {6'd3, 6'd0, 6'd1, 6'd0};
      step(2);
      rst_n = 1'b1;
      step(1); lit("t6_g1", 4'b0010, 0, 0, 1, 1, 0);
      step(1); lit("t6_d1", 0, 4'b0010, 0, 1, 1, 0);
      step(1); lit("t6_idle", 0, 0, 0, 0, 1, 0);
      step(1); lit("t6_g3", 4'b1000, 0, 0, 1, 3, 0);
      step(3); lit("t6_d3", 0, 4'b1000, 0, 1, 3, 2);
      bus.req = '0;
      step(1);

      // Random traffic checked by the model only.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            for (int j = 0; j < int'(NREQ); j++) bus.len[j*int'(W) +: W] = 6'($urandom_range(0, 6));
         end
         step(1);
      end
      bus.req = '0;
      step(70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
